// File: rtl/pixel_shift_engine_if.sv
// Bundle between the WS2812B frame shifter and its bit generator / loader.
// master drives the load and the bit-complete strobe; slave is the shift engine.
interface pixel_shift_engine_if #(
    parameter int FRAME_BITS = 96
);
    localparam int IDX_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    logic                  loadRegister;
    logic [FRAME_BITS-1:0] loadValue;
    logic                  genDone;
    logic                  registerBit;
    logic                  bitValid;
    logic                  latching;
    logic                  frameDone;
    logic [IDX_W-1:0]      bitIndex;

    modport master (
        output loadRegister,
        output loadValue,
        output genDone,
        input  registerBit,
        input  bitValid,
        input  latching,
        input  frameDone,
        input  bitIndex
    );

    modport slave (
        input  loadRegister,
        input  loadValue,
        input  genDone,
        output registerBit,
        output bitValid,
        output latching,
        output frameDone,
        output bitIndex
    );
endinterface

// File: rtl/pixel_shift_engine.sv
// Presents a WS2812B frame MSB-first to the bit generator one bit per genDone,
// then holds the line in a latch gap before repeating (ROTATE=1) or idling.
module pixel_shift_engine #(
    parameter int NUM_LEDS     = 4,
    parameter int BITS_PER_LED = 24,
    parameter int LATCH_CYCLES = 5000,
    parameter int ROTATE       = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    pixel_shift_engine_if.slave    bus
);
    localparam int FRAME_BITS = NUM_LEDS * BITS_PER_LED;
    localparam int IDX_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int LAT_W      = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FRAME_BITS - 1);
    localparam logic [LAT_W-1:0] LAST_LATCH = LAT_W'(LATCH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } engineState_e;

    engineState_e          stateReg;
    engineState_e          stateNext;
    logic [FRAME_BITS-1:0] shiftReg;
    logic [FRAME_BITS-1:0] shiftNext;
    logic [IDX_W-1:0]      indexReg;
    logic [IDX_W-1:0]      indexNext;
    logic [LAT_W-1:0]      latchCount;
    logic [LAT_W-1:0]      latchNext;
    logic                  bitValidComb;
    logic                  latchingComb;
    logic                  frameDoneComb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg   <= IDLE;
            shiftReg   <= '0;
            indexReg   <= '0;
            latchCount <= '0;
        end else begin
            stateReg   <= stateNext;
            shiftReg   <= shiftNext;
            indexReg   <= indexNext;
            latchCount <= latchNext;
        end
    end

    // A load wins over everything; rotating rather than shifting means the register
    // is back at the loaded frame after FRAME_BITS bits, ready to resend.
    always_comb begin
        stateNext     = stateReg;
        shiftNext     = shiftReg;
        indexNext     = indexReg;
        latchNext     = latchCount;
        bitValidComb  = (stateReg == SHIFT);
        latchingComb  = (stateReg == LATCH);
        frameDoneComb = 1'b0;

        if (bus.loadRegister) begin
            shiftNext = bus.loadValue;
            indexNext = '0;
            latchNext = '0;
            stateNext = SHIFT;
        end else begin
            case (stateReg)
                IDLE: begin
                end
                SHIFT: begin
                    if (bus.genDone) begin
                        shiftNext = (shiftReg << 1) | (shiftReg >> (FRAME_BITS - 1));
                        if (indexReg == LAST_IDX) begin
                            indexNext = '0;
                            latchNext = '0;
                            stateNext = LATCH;
                        end else begin
                            indexNext = indexReg + IDX_W'(1);
                        end
                    end
                end
                LATCH: begin
                    if (latchCount == LAST_LATCH) begin
                        frameDoneComb = 1'b1;
                        latchNext     = '0;
                        stateNext     = (ROTATE != 0) ? SHIFT : IDLE;
                    end else begin
                        latchNext = latchCount + LAT_W'(1);
                    end
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    assign bus.registerBit = shiftReg[FRAME_BITS-1];
    assign bus.bitIndex    = indexReg;
    assign bus.bitValid    = bitValidComb;
    assign bus.latching    = latchingComb;
    assign bus.frameDone   = frameDoneComb;

endmodule

// File: tb/tb_pixel_shift_engine.sv
// Bench for pixel_shift_engine: three instances (rotating 96-bit, one-shot 96-bit,
// rotating 3-bit) checked every cycle against a frame/position model plus literals.
module tb_pixel_shift_engine;

    localparam int LATCH_LEN = 8;

    logic        clk = 1'b0;
    logic        rstn  [3];
    logic        load  [3];
    logic [95:0] value [3];
    logic        gen   [3];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pixel_shift_engine_if #(.FRAME_BITS(96)) busA ();
    pixel_shift_engine_if #(.FRAME_BITS(96)) busB ();
    pixel_shift_engine_if #(.FRAME_BITS(3))  busC ();

    assign busA.loadRegister = load[0];
    assign busA.loadValue    = value[0];
    assign busA.genDone      = gen[0];
    assign busB.loadRegister = load[1];
    assign busB.loadValue    = value[1];
    assign busB.genDone      = gen[1];
    assign busC.loadRegister = load[2];
    assign busC.loadValue    = value[2][2:0];
    assign busC.genDone      = gen[2];

    pixel_shift_engine #(.NUM_LEDS(4), .BITS_PER_LED(24), .LATCH_CYCLES(LATCH_LEN), .ROTATE(1))
        dutA (.clk(clk), .reset(rstn[0]), .bus(busA));
    pixel_shift_engine #(.NUM_LEDS(4), .BITS_PER_LED(24), .LATCH_CYCLES(LATCH_LEN), .ROTATE(0))
        dutB (.clk(clk), .reset(rstn[1]), .bus(busB));
    pixel_shift_engine #(.NUM_LEDS(1), .BITS_PER_LED(3), .LATCH_CYCLES(LATCH_LEN), .ROTATE(1))
        dutC (.clk(clk), .reset(rstn[2]), .bus(busC));

    // Model: the loaded frame, how many of its bits have gone out, and the phase
    // (0 idle, 1 sending, 2 latch gap) with the number of gap cycles elapsed.
    logic [95:0] mFrame [3];
    int          mPos   [3];
    int          mMode  [3];
    int          mGap   [3];

    function automatic int fbOf(input int id);
        return (id == 2) ? 3 : 96;
    endfunction

    function automatic void modelClear(input int id);
        mFrame[id] = '0;
        mPos[id]   = 0;
        mMode[id]  = 0;
        mGap[id]   = 0;
    endfunction

    function automatic void modelStep(input int id);
        if (load[id]) begin
            mFrame[id] = (id == 2) ? (value[id] & 96'h7) : value[id];
            mPos[id]   = 0;
            mMode[id]  = 1;
            mGap[id]   = 0;
        end else if (mMode[id] == 1) begin
            if (gen[id]) begin
                mPos[id] = mPos[id] + 1;
                if (mPos[id] == fbOf(id)) begin
                    mPos[id]  = 0;
                    mMode[id] = 2;
                    mGap[id]  = 0;
                end
            end
        end else if (mMode[id] == 2) begin
            if (mGap[id] == LATCH_LEN - 1) begin
                mMode[id] = (id == 1) ? 0 : 1;
                mGap[id]  = 0;
            end else begin
                mGap[id] = mGap[id] + 1;
            end
        end
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rstn[i]) modelClear(i);
            else          modelStep(i);
        end
    end

    always @(negedge rstn[0]) modelClear(0);
    always @(negedge rstn[1]) modelClear(1);
    always @(negedge rstn[2]) modelClear(2);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic compareDut(input int id);
        logic rb, bv, la, fd;
        logic [31:0] bi;
        case (id)
            0: begin rb = busA.registerBit; bv = busA.bitValid; la = busA.latching; fd = busA.frameDone; bi = 32'(busA.bitIndex); end
            1: begin rb = busB.registerBit; bv = busB.bitValid; la = busB.latching; fd = busB.frameDone; bi = 32'(busB.bitIndex); end
            default: begin rb = busC.registerBit; bv = busC.bitValid; la = busC.latching; fd = busC.frameDone; bi = 32'(busC.bitIndex); end
        endcase
        checkOutput($sformatf("dut%0d.registerBit", id), 32'(rb), 32'(mFrame[id][fbOf(id) - 1 - mPos[id]]));
        checkOutput($sformatf("dut%0d.bitValid", id), 32'(bv), 32'(mMode[id] == 1));
        checkOutput($sformatf("dut%0d.latching", id), 32'(la), 32'(mMode[id] == 2));
        checkOutput($sformatf("dut%0d.frameDone", id), 32'(fd),
                    32'(mMode[id] == 2 && mGap[id] == LATCH_LEN - 1 && !load[id]));
        checkOutput($sformatf("dut%0d.bitIndex", id), bi, 32'(mPos[id]));
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) compareDut(i);
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input int id, input logic ld, input logic [95:0] val, input logic g);
        load[id]  = ld;
        value[id] = val;
        gen[id]   = g;
    endtask

    task automatic pulseGen(input int id, input int spacing);
        gen[id] = 1'b1;
        waitCycles(1);
        gen[id] = 1'b0;
        if (spacing > 0) waitCycles(spacing);
    endtask

    logic [47:0] patAB;
    logic [2:0]  patC;

    initial begin
        patAB = 48'hAAAAAA_BBBBBB;
        patC  = 3'b101;
        for (int i = 0; i < 3; i++) begin
            rstn[i] = 1'b0;
            applyStimulus(i, 1'b0, 96'h0, 1'b0);
            modelClear(i);
        end

        // Rotating instance: load held through reset, sequence, latch gap, resend
        applyStimulus(0, 1'b1, 96'hAAAAAA_BBBBBB_AAAAAA_BBBBBB, 1'b0);
        #1;
        checkOutput("A.resetBit", 32'(busA.registerBit), 32'd0);
        checkOutput("A.resetValid", 32'(busA.bitValid), 32'd0);
        #19;
        rstn[0] = 1'b1;
        waitCycles(2);
        load[0] = 1'b0;
        checkOutput("A.firstBit", 32'(busA.registerBit), 32'd1);
        checkOutput("A.firstIndex", 32'(busA.bitIndex), 32'd0);
        checkOutput("A.firstValid", 32'(busA.bitValid), 32'd1);
        for (int i = 0; i < 96; i++) begin
            if (i < 48) checkOutput("A.seq", 32'(busA.registerBit), 32'(patAB[47 - i]));
            checkOutput("A.seqIndex", 32'(busA.bitIndex), 32'(i));
            pulseGen(0, (i == 95) ? 0 : 3);
        end
        for (int k = 0; k < LATCH_LEN; k++) begin
            checkOutput("A.gapLatching", 32'(busA.latching), 32'd1);
            checkOutput("A.gapValid", 32'(busA.bitValid), 32'd0);
            checkOutput("A.gapFrameDone", 32'(busA.frameDone), 32'(k == LATCH_LEN - 1));
            waitCycles(1);
        end
        checkOutput("A.resendValid", 32'(busA.bitValid), 32'd1);
        checkOutput("A.resendBit", 32'(busA.registerBit), 32'd1);
        checkOutput("A.resendIndex", 32'(busA.bitIndex), 32'd0);

        // Abort mid-frame at bit 40, then abort on the final latch cycle
        for (int i = 0; i < 40; i++) pulseGen(0, 3);
        checkOutput("A.midIndex", 32'(busA.bitIndex), 32'd40);
        applyStimulus(0, 1'b1, 96'h800000_000000_000000_000000, 1'b0);
        waitCycles(1);
        load[0] = 1'b0;
        checkOutput("A.abortIndex", 32'(busA.bitIndex), 32'd0);
        checkOutput("A.abortBit", 32'(busA.registerBit), 32'd1);
        for (int i = 0; i < 96; i++) pulseGen(0, (i == 95) ? 0 : 3);
        waitCycles(LATCH_LEN - 1);
        checkOutput("A.lastGapDone", 32'(busA.frameDone), 32'd1);
        load[0] = 1'b1;
        #1;
        checkOutput("A.gapAbortDone", 32'(busA.frameDone), 32'd0);
        waitCycles(1);
        load[0] = 1'b0;
        checkOutput("A.gapAbortLatching", 32'(busA.latching), 32'd0);
        checkOutput("A.gapAbortBit", 32'(busA.registerBit), 32'd1);
        checkOutput("A.gapAbortIndex", 32'(busA.bitIndex), 32'd0);

        // Asynchronous reset between edges at bit 50
        applyStimulus(0, 1'b1, 96'hAAAAAA_BBBBBB_AAAAAA_BBBBBB, 1'b0);
        waitCycles(1);
        load[0] = 1'b0;
        for (int i = 0; i < 50; i++) pulseGen(0, 3);
        checkOutput("A.preResetIndex", 32'(busA.bitIndex), 32'd50);
        checkOutput("A.preResetBit", 32'(busA.registerBit), 32'd1);
        #1;
        rstn[0] = 1'b0;
        #1;
        checkOutput("A.asyncBit", 32'(busA.registerBit), 32'd0);
        checkOutput("A.asyncIndex", 32'(busA.bitIndex), 32'd0);
        checkOutput("A.asyncValid", 32'(busA.bitValid), 32'd0);
        checkOutput("A.asyncLatching", 32'(busA.latching), 32'd0);
        waitCycles(2);
        rstn[0] = 1'b1;
        pulseGen(0, 3);
        pulseGen(0, 3);
        checkOutput("A.postResetIndex", 32'(busA.bitIndex), 32'd0);
        checkOutput("A.postResetValid", 32'(busA.bitValid), 32'd0);
        checkOutput("A.postResetBit", 32'(busA.registerBit), 32'd0);

        // One-shot instance: frame, gap, then idle ignoring genDone
        rstn[1] = 1'b1;
        applyStimulus(1, 1'b1, 96'h800000_000000_000000_000001, 1'b0);
        waitCycles(1);
        load[1] = 1'b0;
        checkOutput("B.firstBit", 32'(busB.registerBit), 32'd1);
        for (int i = 0; i < 96; i++) pulseGen(1, (i == 95) ? 0 : 3);
        for (int k = 0; k < LATCH_LEN; k++) begin
            checkOutput("B.gapFrameDone", 32'(busB.frameDone), 32'(k == LATCH_LEN - 1));
            waitCycles(1);
        end
        checkOutput("B.idleValid", 32'(busB.bitValid), 32'd0);
        checkOutput("B.idleLatching", 32'(busB.latching), 32'd0);
        for (int i = 0; i < 3; i++) pulseGen(1, 3);
        checkOutput("B.idleIndex", 32'(busB.bitIndex), 32'd0);
        checkOutput("B.idleBit", 32'(busB.registerBit), 32'd1);

        // 3-bit instance: load coinciding with genDone must win
        rstn[2] = 1'b1;
        waitCycles(1);
        applyStimulus(2, 1'b1, 96'h5, 1'b0);
        waitCycles(1);
        load[2] = 1'b0;
        pulseGen(2, 3);
        checkOutput("C.preIndex", 32'(busC.bitIndex), 32'd1);
        applyStimulus(2, 1'b1, 96'h5, 1'b1);
        waitCycles(1);
        applyStimulus(2, 1'b0, 96'h5, 1'b0);
        checkOutput("C.loadWinsIndex", 32'(busC.bitIndex), 32'd0);
        checkOutput("C.loadWinsBit", 32'(busC.registerBit), 32'd1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("C.seq", 32'(busC.registerBit), 32'(patC[2 - i]));
            checkOutput("C.seqIndex", 32'(busC.bitIndex), 32'(i));
            pulseGen(2, (i == 2) ? 0 : 3);
        end
        checkOutput("C.latching", 32'(busC.latching), 32'd1);
        checkOutput("C.gapValid", 32'(busC.bitValid), 32'd0);
        waitCycles(12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pixel_shift_engine.md
PIXEL_SHIFT_ENGINE -- requirements
Module: pixel_shift_engine

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 4, the number of WS2812B pixels per frame (>=1).
REQ-002 SHALL have parameter BITS_PER_LED, default 24, the GRB bits per pixel (>=1); FRAME_BITS = NUM_LEDS*BITS_PER_LED.
REQ-003 SHALL have parameter LATCH_CYCLES, default 5000, the number of clk cycles the line is held low after a frame (>=1; 50 us at 100 MHz).
REQ-004 SHALL have parameter ROTATE, default 1, the mode: 1 = frames repeat continuously, 0 = one frame per load.
REQ-005 SHALL have port clk, input, 1, system clock; all state changes on the rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port loadRegister, input, 1, level load request.
REQ-008 SHALL have port loadValue, input, FRAME_BITS, frame data, first-sent bit at the MSB.
REQ-009 SHALL have port genDone, input, 1, a one-cycle pulse from the bit generator when the current bit has been fully transmitted.
REQ-010 SHALL have port registerBit, output, 1, the current bit for the generator (the MSB of the shift register).
REQ-011 SHALL have port bitValid, output, 1, high while the generator is to transmit registerBit.
REQ-012 SHALL have port latching, output, 1, high during the post-frame low (latch) gap.
REQ-013 SHALL have port frameDone, output, 1, a one-cycle pulse when the latch gap completes.
REQ-014 SHALL have port bitIndex, output, clog2(FRAME_BITS) (min 1), the index of the bit currently presented, counting from 0.

Function
REQ-015 SHALL implement the states IDLE, SHIFT and LATCH.
REQ-016 SHALL, on any cycle with loadRegister=1 in any state, capture loadValue into the shift register, clear bitIndex and the latch counter, and enter SHIFT on the next edge; loadRegister has priority over genDone and the latch count.
REQ-017 SHALL reload every cycle while loadRegister is held high, so that shifting begins on the first edge after loadRegister falls.
REQ-018 SHALL, in SHIFT with genDone=1 and loadRegister=0, rotate the register left by one (the MSB wraps into the LSB) and increment bitIndex, with registerBit updated on the same edge.
REQ-019 SHALL, in SHIFT with genDone=1 and bitIndex=FRAME_BITS-1, perform the rotate, wrap bitIndex to 0 and enter LATCH; after FRAME_BITS rotations the register equals the loaded value.
REQ-020 SHALL drive bitValid=1 only in SHIFT, and latching=1 only in LATCH.
REQ-021 SHALL ignore genDone in IDLE and LATCH.
REQ-022 SHALL, in LATCH, count clk cycles; on the cycle where the count reaches LATCH_CYCLES-1, pulse frameDone for exactly one cycle and exit on the next edge.
REQ-023 SHALL exit LATCH to SHIFT when ROTATE=1 (the same frame resends from bit 0), and to IDLE when ROTATE=0.
REQ-024 SHALL hold the register contents unchanged in IDLE and LATCH.
REQ-025 SHALL, when loadRegister is asserted mid-SHIFT or mid-LATCH, abort the current frame with no frameDone pulse and restart per REQ-016.

Reset
REQ-026 SHALL, while reset=0, immediately force the state to IDLE, the register to 0, bitIndex=0, the latch counter=0, and registerBit=0, bitValid=0, latching=0, frameDone=0, independent of clk.
REQ-027 SHALL honour loadRegister from the first rising edge after reset deasserts; a reset asserted mid-frame discards the frame.

Verification
REQ-028 Directed test, defaults except LATCH_CYCLES=8: reset low 20 ns with loadRegister=1 and loadValue=96'hAAAAAA_BBBBBB_AAAAAA_BBBBBB; release reset, then drop loadRegister after 20 ns -> registerBit=1 and bitIndex=0; one genDone pulse per 4 cycles yields the sequence 1,0,1,0... for 24 bits, then 1,0,1,1... (hB) for 24 bits.
REQ-029 Directed test: after 96 genDone pulses -> latching=1 for exactly 8 cycles, frameDone high on the 8th cycle only, bitValid=0 throughout; with ROTATE=1, SHIFT resumes and registerBit=1 (hA MSB) at bitIndex=0.
REQ-030 Directed test, ROTATE=0 -> after frameDone, state is IDLE, bitValid=0, and further genDone pulses leave bitIndex=0 and the register unchanged.
REQ-031 Directed test: loadRegister pulsed with 96'h800...0 at bitIndex=40, and separately during LATCH -> the next cycle shows bitIndex=0, registerBit=1, no frameDone pulse, and the latch gap is not completed.
REQ-032 Directed test: reset asserted asynchronously between clk edges at bitIndex=50 -> all outputs are 0 before the next edge; genDone after release has no effect until a load.
REQ-033 Directed test, NUM_LEDS=1, BITS_PER_LED=3, loadValue=3'b101: genDone asserted on the same cycle as loadRegister -> load wins; the sequence is 1,0,1, then LATCH.
